// File: rtl/paddle_ctrl_accel.sv
// Player paddle controller: a press steps the paddle at once, a held button repeats at a slow
// rate and then at a fast rate; the board edge either clamps or wraps the paddle.
module paddle_ctrl_accel #(
    parameter int c_CoordWidth = 6,
    parameter int c_PaddleX    = 0,
    parameter int c_PaddleLen  = 4,
    parameter int c_GameSize   = 40,
    parameter int c_SlowTicks  = 1250000,
    parameter int c_FastTicks  = 312500,
    parameter int c_AccelSteps = 4,
    parameter int c_WrapEn     = 0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic                    i_PaddleRight,
    input  logic                    i_PaddleLeft,
    input  logic                    i_Enable,
    input  logic [c_CoordWidth-1:0] i_ColCountDiv,
    input  logic [c_CoordWidth-1:0] i_RowCountDiv,
    output logic [c_CoordWidth-1:0] o_PaddlePos,
    output logic                    o_DrawPaddle,
    output logic                    o_Fast,
    output logic                    o_AtEdge
);

    localparam int c_W1       = c_CoordWidth + 1;
    localparam int c_MaxTicks = (c_SlowTicks > c_FastTicks) ? c_SlowTicks : c_FastTicks;
    localparam int c_TickW    = (c_MaxTicks > 1) ? $clog2(c_MaxTicks) : 1;
    localparam int c_StepW    = $clog2(c_AccelSteps + 1);

    localparam logic [c_CoordWidth-1:0] c_Max      = c_CoordWidth'(c_GameSize - c_PaddleLen);
    localparam logic [c_CoordWidth-1:0] c_Start    = c_CoordWidth'((c_GameSize - c_PaddleLen) / 2);
    localparam logic [c_CoordWidth-1:0] c_Row      = c_CoordWidth'(c_PaddleX);
    localparam logic [c_TickW-1:0]      c_SlowLast = c_TickW'(c_SlowTicks - 1);
    localparam logic [c_TickW-1:0]      c_FastLast = c_TickW'(c_FastTicks - 1);
    localparam logic [c_StepW-1:0]      c_Accel    = c_StepW'(c_AccelSteps);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    state_t              state;
    logic [c_TickW-1:0]  tick_cnt;
    logic [c_StepW-1:0]  step_cnt;
    logic                ldir;

    logic                    cmd;
    logic                    dir;
    logic                    moved;
    logic                    tick_hit;
    logic [c_CoordWidth-1:0] step_pos;
    logic [c_StepW-1:0]      step_nxt;
    logic [c_W1-1:0]         col_ext;
    logic [c_W1-1:0]         lo_ext;
    logic [c_W1-1:0]         hi_ext;

    always_comb begin
        cmd      = i_Enable & (i_PaddleRight ^ i_PaddleLeft);
        dir      = i_PaddleLeft;
        step_pos = o_PaddlePos;
        moved    = 1'b0;
        // A blocked step leaves the position alone and reports no movement.
        if (dir) begin
            if (o_PaddlePos == c_Max) begin
                if (c_WrapEn != 0) begin
                    step_pos = '0;
                    moved    = 1'b1;
                end
            end else begin
                step_pos = o_PaddlePos + c_CoordWidth'(1);
                moved    = 1'b1;
            end
        end else begin
            if (o_PaddlePos == '0) begin
                if (c_WrapEn != 0) begin
                    step_pos = c_Max;
                    moved    = 1'b1;
                end
            end else begin
                step_pos = o_PaddlePos - c_CoordWidth'(1);
                moved    = 1'b1;
            end
        end

        tick_hit = (state == FAST) ? (tick_cnt == c_FastLast) : (tick_cnt == c_SlowLast);
        step_nxt = step_cnt;
        if (tick_hit && moved && (step_cnt < c_Accel))
            step_nxt = step_cnt + c_StepW'(1);

        col_ext = {1'b0, i_ColCountDiv};
        lo_ext  = {1'b0, o_PaddlePos};
        hi_ext  = lo_ext + c_W1'(c_PaddleLen);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            o_PaddlePos  <= c_Start;
            tick_cnt     <= '0;
            step_cnt     <= '0;
            ldir         <= 1'b0;
            o_DrawPaddle <= 1'b0;
        end else begin
            o_DrawPaddle <= (i_RowCountDiv == c_Row) && (col_ext >= lo_ext) && (col_ext < hi_ext);

            if (!cmd || ((state != IDLE) && (dir != ldir))) begin
                state    <= IDLE;
                tick_cnt <= '0;
                step_cnt <= '0;
            end else if (state == IDLE) begin
                o_PaddlePos <= step_pos;
                ldir        <= dir;
                tick_cnt    <= '0;
                step_cnt    <= moved ? c_StepW'(1) : '0;
                state       <= SLOW;
            end else begin
                step_cnt <= step_nxt;
                if (tick_hit) begin
                    o_PaddlePos <= step_pos;
                    tick_cnt    <= '0;
                end else begin
                    tick_cnt <= tick_cnt + c_TickW'(1);
                end
                // Checking the updated count lets a count already at target promote on the first SLOW cycle.
                if (step_nxt >= c_Accel)
                    state <= FAST;
            end
        end
    end

    assign o_Fast   = (state == FAST);
    assign o_AtEdge = (o_PaddlePos == '0) || (o_PaddlePos == c_Max);

endmodule

// File: tb/tb_paddle_ctrl_accel.sv
// Scoreboard bench for paddle_ctrl_accel: a clamp instance and a wrap instance on a 10-cell board.
module tb_paddle_ctrl_accel;

    logic       clk = 1'b0;
    logic       i_Rst_n = 1'b0;
    logic       i_Enable = 1'b1;
    logic       l0 = 1'b0, r0 = 1'b0, l1 = 1'b0, r1 = 1'b0;
    logic [5:0] row = 6'd9;
    logic [5:0] col = 6'd0;

    logic [5:0] pos0, pos1;
    logic       draw0, draw1, fast0, fast1, edge0, edge1;

    logic rst_v = 1'b0;
    logic en_v  = 1'b1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit    sel;
        int    pos;
        bit    fast;
        bit    draw;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    paddle_ctrl_accel #(
        .c_CoordWidth(6), .c_PaddleX(0), .c_PaddleLen(3), .c_GameSize(10),
        .c_SlowTicks(4), .c_FastTicks(2), .c_AccelSteps(3), .c_WrapEn(0)
    ) dut_clamp (
        .i_Clk(clk), .i_Rst_n(i_Rst_n), .i_PaddleRight(r0), .i_PaddleLeft(l0),
        .i_Enable(i_Enable), .i_ColCountDiv(col), .i_RowCountDiv(row),
        .o_PaddlePos(pos0), .o_DrawPaddle(draw0), .o_Fast(fast0), .o_AtEdge(edge0)
    );

    paddle_ctrl_accel #(
        .c_CoordWidth(6), .c_PaddleX(0), .c_PaddleLen(3), .c_GameSize(10),
        .c_SlowTicks(4), .c_FastTicks(2), .c_AccelSteps(3), .c_WrapEn(1)
    ) dut_wrap (
        .i_Clk(clk), .i_Rst_n(i_Rst_n), .i_PaddleRight(r1), .i_PaddleLeft(l1),
        .i_Enable(i_Enable), .i_ColCountDiv(col), .i_RowCountDiv(row),
        .o_PaddlePos(pos1), .o_DrawPaddle(draw1), .o_Fast(fast1), .o_AtEdge(edge1)
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: the outputs after every edge are compared against the oldest queued expectation.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".pos"},  e.sel ? int'(pos1)  : int'(pos0),  e.pos);
            chk({e.name, ".fast"}, e.sel ? int'(fast1) : int'(fast0), int'(e.fast));
            chk({e.name, ".edge"}, e.sel ? int'(edge1) : int'(edge0),
                ((e.pos == 0) || (e.pos == 7)) ? 1 : 0);
            chk({e.name, ".draw"}, e.sel ? int'(draw1) : int'(draw0), int'(e.draw));
        end
    end

    task automatic step(input bit sel, input logic l, input logic r, input logic [5:0] rv,
                        input logic [5:0] cv, input int ep, input bit ef, input bit ed,
                        input string nm);
        exp_t x;
        #1;
        i_Rst_n  = rst_v;
        i_Enable = en_v;
        row      = rv;
        col      = cv;
        l0 = sel ? 1'b0 : l;
        r0 = sel ? 1'b0 : r;
        l1 = sel ? l : 1'b0;
        r1 = sel ? r : 1'b0;
        @(posedge clk);
        x.sel  = sel;
        x.pos  = ep;
        x.fast = ef;
        x.draw = ed;
        x.name = nm;
        sb.push_back(x);
    endtask

    // One cycle per character: ps holds the expected position digits, fs the expected o_Fast bits.
    task automatic hold(input bit sel, input logic l, input logic r, input string ps,
                        input string fs, input string nm);
        for (int i = 0; i < ps.len(); i++)
            step(sel, l, r, 6'd9, 6'd0, int'(ps.getc(i)) - 48, fs.getc(i) == 8'h31, 1'b0, nm);
    endtask

    initial begin
        rst_v = 1'b0;
        hold(0, 0, 0, "33", "00", "reset");
        rst_v = 1'b1;

        hold(0, 1, 0, "44445555667777", "00000000111111", "clamp_hold");
        hold(0, 0, 1, "766", "000", "reversal");
        hold(0, 0, 0, "6", "0", "release");
        hold(0, 1, 1, "6666", "0000", "both_buttons");

        en_v = 1'b0;
        hold(0, 0, 1, "666", "000", "disabled");
        en_v = 1'b1;
        hold(0, 0, 1, "55554444332", "00000000111", "run_fast");
        rst_v = 1'b0;
        hold(0, 0, 1, "3", "0", "reset_mid_fast");
        rst_v = 1'b1;
        hold(0, 0, 0, "3", "0", "after_reset");

        for (int c = 0; c < 10; c++)
            step(0, 0, 0, 6'd0, 6'(c), 3, 1'b0, (c >= 3) && (c <= 5), "draw_row0");
        step(0, 0, 0, 6'd1, 6'd4, 3, 1'b0, 1'b0, "draw_row1");
        step(0, 0, 0, 6'd9, 6'd3, 3, 1'b0, 1'b0, "draw_row9");

        hold(0, 0, 1, "22221111000", "00000000111", "to_zero");
        hold(0, 0, 0, "0", "0", "release_zero");
        hold(0, 0, 1, "000000000000", "000000000000", "blocked_hold");

        hold(1, 0, 1, "222211110", "000000001", "wrap_down");
        hold(1, 0, 0, "0", "0", "wrap_release");
        hold(1, 0, 1, "7", "0", "wrap_minus");
        hold(1, 0, 0, "7", "0", "wrap_idle");
        hold(1, 1, 0, "0", "0", "wrap_plus");
        hold(1, 0, 0, "0", "0", "wrap_idle2");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
